list_range_source: RTL and testbench

Responder (producer) end of the req/ack/eol/value list-stream handshake used between generated list modules and their consumers. Produces the arithmetic sequence equivalent to Haskell `[start, start+step .. stop]` one element per request. Sits wherever a compiled range expression feeds a list consumer: a fold, map stage or a board-level test harness driving `req`.

---
 rtl/list_range_if.sv | 37 +++
 rtl/list_range_source.sv | 141 ++++++++++++++
 tb/tb_list_range_source.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/list_range_if.sv
// list_range_if: req/ack/eol/value list-stream handshake between a list producer and its consumer.
// `count` is present only when LIST_RANGE_COUNT_EN is defined.
interface list_range_if #(
  parameter int unsigned WIDTH = 8
);
  logic                    req;
  logic                    ack;
  logic                    eol;
  logic signed [WIDTH-1:0] value;
`ifdef LIST_RANGE_COUNT_EN
  logic [WIDTH-1:0]        count;
`endif

  // Consumer side drives req and observes the element stream
  modport master (
    output req,
    input  ack,
    input  eol,
    input  value
`ifdef LIST_RANGE_COUNT_EN
    ,
    input  count
`endif
  );

  // Producer side answers requests
  modport slave (
    input  req,
    output ack,
    output eol,
    output value
`ifdef LIST_RANGE_COUNT_EN
    ,
    output count
`endif
  );
endinterface

// File: rtl/list_range_source.sv
// list_range_source: producer of [start, start+step .. stop], one element per req/ack handshake.
// Optional element counter on lst.count under macro LIST_RANGE_COUNT_EN.
module list_range_source #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic                    running,
  input  logic signed [WIDTH-1:0] start,
  input  logic signed [WIDTH-1:0] step,
  input  logic signed [WIDTH-1:0] stop,
  list_range_if.slave             lst
);
  localparam int unsigned W = WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_REQ,
    S_ACK,
    S_WAIT_DROP
  } state_t;

  state_t              r_state, w_state_nxt;
  logic signed [W-1:0] r_cur, w_cur_nxt;
  logic signed [W-1:0] r_step, w_step_nxt;
  logic signed [W-1:0] r_stop, w_stop_nxt;
  logic                r_exh, w_exh_nxt;
  logic                r_ack, w_ack_nxt;
  logic                r_eol, w_eol_nxt;
  logic signed [W-1:0] r_value, w_value_nxt;
  logic [W:0]          w_sum;
  logic                w_ovf;
`ifdef LIST_RANGE_COUNT_EN
  logic [W-1:0]        r_count, w_count_nxt;
`endif

  // Element is past the bound in the direction of travel; step 0 compares start against stop
  function automatic logic f_exhausted(input logic signed [W-1:0] cur,
                                       input logic signed [W-1:0] inc,
                                       input logic signed [W-1:0] lim);
    logic neg;
    neg = inc[W-1];
    f_exhausted = neg ? (cur < lim) : (cur > lim);
  endfunction

  // Sign-extended next element; a mismatch of the top two bits is a signed overflow
  assign w_sum = {r_cur[W-1], r_cur} + {r_step[W-1], r_step};
  assign w_ovf = w_sum[W] ^ w_sum[W-1];

  always_comb begin
    w_state_nxt = r_state;
    w_cur_nxt   = r_cur;
    w_step_nxt  = r_step;
    w_stop_nxt  = r_stop;
    w_exh_nxt   = r_exh;
    w_ack_nxt   = 1'b0;
    w_eol_nxt   = r_eol;
    w_value_nxt = r_value;
`ifdef LIST_RANGE_COUNT_EN
    w_count_nxt = r_count;
`endif
    if (!running) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_WAIT_REQ;
          w_cur_nxt   = start;
          w_step_nxt  = step;
          w_stop_nxt  = stop;
          w_exh_nxt   = f_exhausted(start, step, stop);
`ifdef LIST_RANGE_COUNT_EN
          w_count_nxt = '0;
`endif
        end
        S_WAIT_REQ: begin
          if (lst.req) begin
            w_state_nxt = S_ACK;
            w_ack_nxt   = 1'b1;
            if (r_exh) begin
              w_value_nxt = '0;
              w_eol_nxt   = 1'b1;
            end else begin
              w_value_nxt = r_cur;
              w_eol_nxt   = 1'b0;
              w_cur_nxt   = w_sum[W-1:0];
              w_exh_nxt   = w_ovf || f_exhausted(w_sum[W-1:0], r_step, r_stop);
`ifdef LIST_RANGE_COUNT_EN
              w_count_nxt = r_count + W'(1);
`endif
            end
          end
        end
        S_ACK: begin
          w_state_nxt = S_WAIT_DROP;
        end
        S_WAIT_DROP: begin
          if (!lst.req) w_state_nxt = S_WAIT_REQ;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cur   <= '0;
      r_step  <= '0;
      r_stop  <= '0;
      r_exh   <= 1'b0;
      r_ack   <= 1'b0;
      r_eol   <= 1'b0;
      r_value <= '0;
`ifdef LIST_RANGE_COUNT_EN
      r_count <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cur   <= w_cur_nxt;
      r_step  <= w_step_nxt;
      r_stop  <= w_stop_nxt;
      r_exh   <= w_exh_nxt;
      r_ack   <= w_ack_nxt;
      r_eol   <= w_eol_nxt;
      r_value <= w_value_nxt;
`ifdef LIST_RANGE_COUNT_EN
      r_count <= w_count_nxt;
`endif
    end
  end

  assign lst.ack   = r_ack;
  assign lst.eol   = r_eol;
  assign lst.value = r_value;
`ifdef LIST_RANGE_COUNT_EN
  assign lst.count = r_count;
`endif
endmodule

// File: tb/tb_list_range_source.sv
// tb_list_range_source: directed and random lists checked against an arithmetic-sequence model.
// Build with LIST_RANGE_COUNT_EN defined to also check the element counter.
module tb_list_range_source;
  localparam int unsigned W = 8;

  logic                clk = 1'b0;
  logic                reset;
  logic                running;
  logic signed [W-1:0] start;
  logic signed [W-1:0] step;
  logic signed [W-1:0] stop;

  list_range_if #(.WIDTH(W)) lst ();

  list_range_source #(.WIDTH(W)) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .running  (running),
    .start    (start),
    .step     (step),
    .stop     (stop),
    .lst      (lst)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: list parameters, index of next element, elements delivered
  int m_start, m_step, m_stop, m_k, m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // k-th element is start + k*step in unbounded integers; past stop (or out of range) means eol
  task automatic exp_elem(input int k, output int v, output bit e);
    v = m_start + k * m_step;
    e = (m_step > 0 && v > m_stop) || (m_step < 0 && v < m_stop) ||
        (m_step == 0 && m_start > m_stop);
    if (e) v = 0;
  endtask

  task automatic start_list(input int s, input int st, input int sp);
    running = 1'b0;
    lst.req = 1'b0;
    tick();
    start   = W'(s);
    step    = W'(st);
    stop    = W'(sp);
    running = 1'b1;
    tick();
    // Parameters must only be sampled on the IDLE exit
    start   = W'($urandom);
    step    = W'($urandom);
    stop    = W'($urandom);
    m_start = s;
    m_step  = st;
    m_stop  = sp;
    m_k     = 0;
    m_cnt   = 0;
`ifdef LIST_RANGE_COUNT_EN
    check("count_clear", {24'd0, lst.count}, 32'd0);
`endif
  endtask

  task automatic transact(input string tag, input int hold);
    int v;
    bit e;
    int cyc;
    bit got;
    int extra;
    exp_elem(m_k, v, e);
    lst.req = 1'b1;
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < 8) begin
      tick();
      cyc++;
      got = lst.ack;
    end
    check({tag, ".ack"}, 32'(got), 32'd1);
    check({tag, ".latency"}, 32'(cyc), 32'd1);
    check({tag, ".value"}, {24'd0, lst.value}, 32'(v & 255));
    check({tag, ".eol"}, 32'(lst.eol), 32'(e));
    if (!e) m_cnt = (m_cnt + 1) % 256;
`ifdef LIST_RANGE_COUNT_EN
    check({tag, ".count"}, {24'd0, lst.count}, 32'(m_cnt));
`endif
    m_k++;
    extra = 0;
    repeat (hold) begin
      tick();
      if (lst.ack) extra++;
    end
    lst.req = 1'b0;
    repeat (2) begin
      tick();
      if (lst.ack) extra++;
    end
    check({tag, ".pulses"}, 32'(extra), 32'd0);
    check({tag, ".hold"}, {24'd0, lst.value, 7'd0, lst.eol}, 32'(((v & 255) << 8) | int'(e)));
  endtask

  initial begin
    int s, st, sp, n;
    reset   = 1'b1;
    running = 1'b0;
    lst.req = 1'b0;
    start   = '0;
    step    = '0;
    stop    = '0;
    tick();
    tick();
    check("rst.ack", 32'(lst.ack), 32'd0);
    check("rst.eol", 32'(lst.eol), 32'd0);
    check("rst.value", {24'd0, lst.value}, 32'd0);
`ifdef LIST_RANGE_COUNT_EN
    check("rst.count", {24'd0, lst.count}, 32'd0);
`endif
    reset = 1'b0;
    tick();

    start_list(2, 10, 30);
    for (int i = 0; i < 5; i++) transact("up", 0);

    start_list(5, -2, 0);
    for (int i = 0; i < 4; i++) transact("down", 0);

    start_list(3, 1, 2);
    transact("empty", 0);

    start_list(7, 0, 7);
    for (int i = 0; i < 10; i++) transact("const", 0);

    start_list(120, 5, 127);
    for (int i = 0; i < 4; i++) transact("ovf", 0);

    start_list(-120, -5, -128);
    for (int i = 0; i < 3; i++) transact("ovf_neg", 1);

    start_list(0, 3, 20);
    transact("held", 6);
    transact("held_next", 0);

    // Dropping running mid-list then restarting
    start_list(2, 10, 30);
    transact("pre_drop", 0);
    transact("pre_drop", 0);
    running = 1'b0;
    tick();
    check("drop.ack", 32'(lst.ack), 32'd0);
    check("drop.value", {24'd0, lst.value}, 32'd12);
    start_list(1, 1, 3);
    for (int i = 0; i < 4; i++) transact("restart", 0);

    // Running falls during the ACK cycle: that ack stands, no further ack
    start_list(40, 1, 50);
    lst.req = 1'b1;
    tick();
    check("rfall.ack", 32'(lst.ack), 32'd1);
    check("rfall.value", {24'd0, lst.value}, 32'd40);
    running = 1'b0;
    tick();
    check("rfall.ack_after", 32'(lst.ack), 32'd0);
    tick();
    check("rfall.idle", 32'(lst.ack), 32'd0);
    lst.req = 1'b0;

    // Reset during ACK
    start_list(10, 1, 50);
    lst.req = 1'b1;
    tick();
    check("rstack.ack_before", 32'(lst.ack), 32'd1);
    reset = 1'b1;
    tick();
    check("rstack.ack", 32'(lst.ack), 32'd0);
    check("rstack.value", {24'd0, lst.value}, 32'd0);
    check("rstack.eol", 32'(lst.eol), 32'd0);
    reset = 1'b0;
    lst.req = 1'b0;
    tick();

    // Random lists
    for (int t = 0; t < 30; t++) begin
      s = int'($urandom_range(0, 255)) - 128;
      if ($urandom_range(0, 3) == 0) st = int'($urandom_range(0, 255)) - 128;
      else st = int'($urandom_range(0, 16)) - 8;
      sp = s + int'($urandom_range(0, 60)) - 20;
      if (sp > 127) sp = 127;
      if (sp < -128) sp = -128;
      n = int'($urandom_range(1, 12));
      start_list(s, st, sp);
      for (int i = 0; i < n; i++) transact("rand", int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
